// File: rtl/matrix_bram_writer_if.sv
// Element stream in, BRAM write port out, as seen by matrix_bram_writer.
// master = writer side, slave = stream source / BRAM side.
interface matrix_bram_writer_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [31:0]           elem_data;
  logic                  elem_valid;
  logic                  elem_ready;
  logic                  bram_wr_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_din;

  modport master (
    input  elem_data, elem_valid,
    output elem_ready, bram_wr_en, bram_addr, bram_din
  );

  modport slave (
    output elem_data, elem_valid,
    input  elem_ready, bram_wr_en, bram_addr, bram_din
  );
endinterface

// File: rtl/matrix_bram_writer.sv
// Writes one matrix (header, two reserved words, row-major elements)
// into its BRAM slot; an abort invalidates the slot header.
module matrix_bram_writer #(
  parameter int BLOCK_SIZE   = 1152,
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_MATRICES = 8,
  parameter int MAX_DIM      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           matrix_id,
  input  logic [7:0]           rows,
  input  logic [7:0]           cols,
  input  logic                 abort,
  matrix_bram_writer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] BLK = AW'(BLOCK_SIZE);

  if (NUM_MATRICES * BLOCK_SIZE > 2 ** ADDR_WIDTH) begin : g_bad_slots
    $error("matrix slots exceed BRAM address space");
  end
  if (MAX_DIM * MAX_DIM + 3 > BLOCK_SIZE) begin : g_bad_dim
    $error("MAX_DIM matrix does not fit in one slot");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_HDR,
    S_RSV1,
    S_RSV2,
    S_DATA,
    S_FIN,
    S_INVAL,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [2:0]    id_q;
  logic [7:0]    rows_q;
  logic [7:0]    cols_q;
  logic [AW-1:0] base;
  logic [AW-1:0] total;
  logic [AW-1:0] idx;
  logic          dims_bad;
  logic          fire;
  logic          last;

  assign bus.elem_ready = (state == S_DATA) && !abort;
  assign fire = bus.elem_valid && bus.elem_ready;
  assign last = (idx == total - AW'(1));

  assign dims_bad = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                    (int'(rows_q) > MAX_DIM) ||
                    (int'(cols_q) > MAX_DIM) ||
                    (int'(id_q) >= NUM_MATRICES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = dims_bad ? S_ERR : S_HDR;
      S_HDR:   state_nx = abort ? S_INVAL : S_RSV1;
      S_RSV1:  state_nx = abort ? S_INVAL : S_RSV2;
      S_RSV2:  state_nx = abort ? S_INVAL : S_DATA;
      S_DATA: begin
        if (abort)             state_nx = S_INVAL;
        else if (fire && last) state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      S_INVAL: state_nx = S_ERR;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q           <= '0;
      rows_q         <= '0;
      cols_q         <= '0;
      base           <= '0;
      total          <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      bus.bram_wr_en <= 1'b0;
      bus.bram_addr  <= '0;
      bus.bram_din   <= '0;
    end else begin
      bus.bram_wr_en <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            id_q   <= matrix_id;
            rows_q <= rows;
            cols_q <= cols;
            idx    <= '0;
            busy   <= 1'b1;
          end
        end
        S_CHECK: begin
          base  <= AW'(id_q) * BLK;
          total <= AW'(rows_q) * AW'(cols_q);
        end
        S_HDR: begin
          bus.bram_wr_en <= 1'b1;
          bus.bram_addr  <= base;
          bus.bram_din   <= {rows_q, cols_q, 16'd0};
        end
        S_RSV1: begin
          bus.bram_wr_en <= 1'b1;
          bus.bram_addr  <= base + AW'(1);
          bus.bram_din   <= '0;
        end
        S_RSV2: begin
          bus.bram_wr_en <= 1'b1;
          bus.bram_addr  <= base + AW'(2);
          bus.bram_din   <= '0;
        end
        S_DATA: begin
          // Address tracks the element index, so stream gaps leave no holes.
          if (fire) begin
            bus.bram_wr_en <= 1'b1;
            bus.bram_addr  <= base + AW'(3) + idx;
            bus.bram_din   <= bus.elem_data;
            idx            <= idx + AW'(1);
          end
        end
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_INVAL: begin
          bus.bram_wr_en <= 1'b1;
          bus.bram_addr  <= base;
          bus.bram_din   <= '0;
        end
        S_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
